// File: rtl/shift_add_mul_ctrl_if.sv
// Handshake and step-counter bundle for shift_add_mul_ctrl.
// The slave modport is the multiplier; the master is whoever drives the requests and the Counter value.
interface shift_add_mul_ctrl_if #(
  parameter int unsigned CNT_W = 3,
  parameter int unsigned WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [CNT_W-1:0]     count;
  logic                 count_up;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;
  logic                 err;

  modport slave (
    input  start, a, b, count,
    output count_up, busy, done, product, err
  );

  modport master (
    output start, a, b, count,
    input  count_up, busy, done, product, err
  );
endinterface

// File: rtl/shift_add_mul_ctrl.sv
// Sequential 8x8 unsigned shift-add multiplier whose step index comes from an external 3-bit Counter.
// Optional macro SEQ_CHECK_EN adds a shadow step counter that raises a sticky err on sequencing faults.
module shift_add_mul_ctrl #(
  parameter int unsigned CNT_W = 3,
  parameter int unsigned WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  shift_add_mul_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               count_up_q, count_up_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH:0]     sum_c;
  logic               accept_c;
  logic               last_step_c;

  assign accept_c    = (state_q == S_IDLE) && bus.start;
  assign last_step_c = (bus.count == CNT_W'(WIDTH - 1));

  // State register; handshake outputs are registered from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      count_up_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      count_up_q <= count_up_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (last_step_c) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_d     = 1'b0;
    done_d     = 1'b0;
    count_up_d = 1'b0;
    unique case (state_d)
      S_RUN:   begin
        busy_d     = 1'b1;
        count_up_d = 1'b1;
      end
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

  // One add-and-shift step: A gets the upper bits, the carried-out LSB enters Q from the top
  assign sum_c = {1'b0, a_q} + (q_q[0] ? {1'b0, m_q} : (WIDTH + 1)'(0));

  always_comb begin
    m_d = m_q;
    a_d = a_q;
    q_d = q_q;
    if (accept_c) begin
      m_d = bus.a;
      q_d = bus.b;
      a_d = '0;
    end else if (state_q == S_RUN) begin
      a_d = sum_c[WIDTH:1];
      q_d = {sum_c[0], q_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q <= '0;
      a_q <= '0;
      q_q <= '0;
    end else begin
      m_q <= m_d;
      a_q <= a_d;
      q_q <= q_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.count_up = count_up_q;
  assign bus.product  = {a_q, q_q};

`ifdef SEQ_CHECK_EN
  logic [CNT_W-1:0] shadow_q;
  logic             err_q;

  // Shadow mirrors the Counter; any disagreement or a start away from step 0 latches err
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (count_up_q) shadow_q <= shadow_q + CNT_W'(1);
      if ((bus.count != shadow_q) || (accept_c && (bus.count != '0))) err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// Self-checking bench for shift_add_mul_ctrl with a behavioural model of the 3-bit step Counter.
// Expected products come from plain multiplication; timing expectations from the cycle schedule.
module tb_shift_add_mul_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  logic [2:0] cnt_q;
  logic       force_en;
  logic [2:0] force_val;

  shift_add_mul_ctrl_if #(.CNT_W(3), .WIDTH(8)) bus ();

  shift_add_mul_ctrl #(.CNT_W(3), .WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Counter model: clears with the shared reset, counts on count_up, wraps naturally at 3 bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= 3'd0;
    else if (bus.count_up) cnt_q <= cnt_q + 3'd1;
  end

  assign bus.count = force_en ? force_val : cnt_q;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full operation from IDLE, checking the cycle-by-cycle schedule and the product
  task automatic do_op(input logic [7:0] x, input logic [7:0] y);
    logic [15:0] exp;
    exp = 16'(int'(x) * int'(y));
    bus.start = 1'b1; bus.a = x; bus.b = y;
    step();
    bus.start = 1'b0; bus.a = 8'($urandom); bus.b = 8'($urandom);
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.count_up !== 1'b1) begin
        failures++;
        $display("FAIL run_flags cyc=%0d busy=%b done=%b count_up=%b required 1/0/1", i, bus.busy, bus.done, bus.count_up);
      end
      checks++;
      if (bus.count !== 3'(i - 1)) begin
        failures++;
        $display("FAIL run_count cyc=%0d got %0d required %0d", i, bus.count, i - 1);
      end
      step();
    end
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.count_up !== 1'b0) begin
      failures++;
      $display("FAIL done_flags done=%b busy=%b count_up=%b required 1/0/0", bus.done, bus.busy, bus.count_up);
    end
    checks++;
    if (bus.product !== exp) begin
      failures++;
      $display("FAIL product a=%0d b=%0d got 0x%04h required 0x%04h", x, y, bus.product, exp);
    end
    checks++;
    if (bus.count !== 3'd0 || bus.err !== 1'b0) begin
      failures++;
      $display("FAIL done_count_err count=%0d err=%b required 0/0", bus.count, bus.err);
    end
    step();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.product !== exp) begin
      failures++;
      $display("FAIL idle_hold done=%b busy=%b product=0x%04h required 0/0/0x%04h", bus.done, bus.busy, bus.product, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.count_up !== 1'b0 || bus.product !== 16'h0 || bus.err !== 1'b0) begin
      failures++;
      $display("FAIL reset_state busy=%b done=%b count_up=%b product=0x%04h err=%b required all 0",
               bus.busy, bus.done, bus.count_up, bus.product, bus.err);
    end
    reset = 1'b0;
    step();
    checks++;
    if (bus.busy !== 1'b0 || bus.count !== 3'd0) begin
      failures++;
      $display("FAIL post_reset_idle busy=%b count=%0d required 0/0", bus.busy, bus.count);
    end
  endtask

  task automatic test_basic();
    do_op(8'd13, 8'd11);
  endtask

  task automatic test_corners();
    do_op(8'd255, 8'd255);
    do_op(8'd0, 8'd200);
    do_op(8'd1, 8'd255);
    do_op(8'd255, 8'd0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) do_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
  endtask

  // start stays high throughout: exactly one op per 10 cycles, next one picks up new operands
  task automatic test_hold_start();
    int done_cnt;
    done_cnt = 0;
    bus.start = 1'b1; bus.a = 8'd3; bus.b = 8'd5;
    step();
    for (int i = 1; i <= 9; i++) begin
      if (bus.done === 1'b1) done_cnt++;
      if (i == 9) begin
        checks++;
        if (bus.product !== 16'd15) begin
          failures++;
          $display("FAIL hold_first_product got %0d required 15", bus.product);
        end
        bus.a = 8'd7; bus.b = 8'd9;
      end
      step();
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || done_cnt != 1) begin
      failures++;
      $display("FAIL hold_gap busy=%b done=%b done_pulses=%0d required 0/0/1", bus.busy, bus.done, done_cnt);
    end
    step();
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.count !== 3'd0) begin
      failures++;
      $display("FAIL hold_second_accept busy=%b count=%0d required 1/0", bus.busy, bus.count);
    end
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (bus.done !== 1'b1 || bus.product !== 16'd63) begin
      failures++;
      $display("FAIL hold_second_product done=%b got %0d required 1/63", bus.done, bus.product);
    end
    step();
  endtask

  task automatic test_reset_mid_run();
    int budget;
    bus.start = 1'b1; bus.a = 8'd200; bus.b = 8'd177;
    step();
    bus.start = 1'b0;
    budget = 0;
    while (bus.count !== 3'd4 && budget < 12) begin
      step();
      budget++;
    end
    checks++;
    if (bus.count !== 3'd4 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL midrun_reach count=%0d busy=%b required 4/1", bus.count, bus.busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.product !== 16'h0 || bus.count !== 3'd0 || bus.count_up !== 1'b0) begin
      failures++;
      $display("FAIL midrun_reset busy=%b product=0x%04h count=%0d count_up=%b required 0/0/0/0",
               bus.busy, bus.product, bus.count, bus.count_up);
    end
    step();
    reset = 1'b0;
    step();
    do_op(8'd20, 8'd10);
  endtask

  // Single-cycle start pulses in RUN and DONE must not launch another operation
  task automatic test_ignored_start();
    int done_cnt;
    done_cnt = 0;
    bus.start = 1'b1; bus.a = 8'd6; bus.b = 8'd7;
    step();
    bus.start = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      bus.start = (i == 3 || i == 9);
      bus.a = 8'd99; bus.b = 8'd99;
      if (bus.done === 1'b1) done_cnt++;
      if (i == 9) begin
        checks++;
        if (bus.product !== 16'd42) begin
          failures++;
          $display("FAIL ignored_product got %0d required 42", bus.product);
        end
      end
      if (i >= 10) begin
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
          failures++;
          $display("FAIL ignored_idle cyc=%0d busy=%b done=%b required 0/0", i, bus.busy, bus.done);
        end
      end
      step();
    end
    bus.start = 1'b0;
    checks++;
    if (done_cnt != 1 || bus.product !== 16'd42) begin
      failures++;
      $display("FAIL ignored_pulses done_pulses=%0d product=%0d required 1/42", done_cnt, bus.product);
    end
  endtask

`ifdef SEQ_CHECK_EN
  task automatic test_seq_check();
    force_en = 1'b1; force_val = 3'd5;
    bus.start = 1'b1; bus.a = 8'd2; bus.b = 8'd3;
    step();
    force_en = 1'b0; bus.start = 1'b0;
    checks++;
    if (bus.err !== 1'b1) begin
      failures++;
      $display("FAIL seq_err_set got %b required 1", bus.err);
    end
    for (int i = 0; i < 12; i++) step();
    checks++;
    if (bus.err !== 1'b1) begin
      failures++;
      $display("FAIL seq_err_sticky got %b required 1", bus.err);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    checks++;
    if (bus.err !== 1'b0) begin
      failures++;
      $display("FAIL seq_err_cleared got %b required 0", bus.err);
    end
    do_op(8'd17, 8'd19);
  endtask
`endif

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0;
    force_en = 1'b0; force_val = '0;
    test_reset();
    test_basic();
    test_corners();
    test_random();
    test_hold_start();
    test_reset_mid_run();
    test_ignored_start();
`ifdef SEQ_CHECK_EN
    test_seq_check();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
